atomic_counter_bank: RTL and testbench
======================================

# atomic_counter_bank

Multi-channel event counter bank with coherent wide-counter readout over a narrow bus. Each of NUM_CH channels counts single-cycle trig pulses in a CNT_W-bit wrapping counter. An atomic read snapshots the full selected counter into a shared shadow register and returns its low word. Follow-up non-atomic reads return the remaining words of that same snapshot, so software sees a tear-free value while counting continues. The block sits between event sources and the register-bus slave, replacing the single-channel 64/32 counter.

## Interface
- NUM_CH, 4, number of independent counter channels (1..64)
- CNT_W, 64, counter width in bits; integer multiple of BUS_W
- BUS_W, 32, readout word width; NWORDS = CNT_W/BUS_W, SEL_W = max(1, clog2(NUM_CH))
- clk  input  1  single clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- trig_i  input  NUM_CH  per-channel increment pulse, +1 per cycle high
- req_i  input  1  read request, one per cycle, no backpressure
- atomic_i  input  1  qualifies req_i: 1 = snapshot + word 0, 0 = next shadow word
- ch_sel_i  input  SEL_W  channel for atomic read; ignored when atomic_i=0
- ack_o  output  1  read response valid
- count_o  output  BUS_W  read data; 0 whenever ack_o=0
- ovf_o  output  NUM_CH  sticky per-channel wrap flag

## Operation
- Counters: cnt[c] <= cnt[c] + trig_i[c] every cycle, modulo 2^CNT_W. Wrap (all-ones + 1) sets ovf_o[c].
- Atomic read (req_i=1, atomic_i=1, ch_sel_i < NUM_CH): shadow <= cnt[sel] + trig_i[sel] (post-update value), ptr <= 1 mod NWORDS, response = shadow word 0. ovf_o[sel] clears. A wrap on the same channel in the same cycle wins: ovf_o[sel] stays 1.
- Non-atomic read (req_i=1, atomic_i=0): response = shadow word ptr (word k = bits [k*BUS_W +: BUS_W]); ptr <= (ptr+1) mod NWORDS. Shadow unchanged. The counters are never disturbed.
- Out-of-range ch_sel_i (>= NUM_CH) on atomic read: ack_o=1, count_o=0. shadow, ptr and ovf_o are unchanged.
- Non-atomic read before any atomic read returns 0 (shadow reset value).
- Reads and triggers are independent: every channel may trig while any read is in progress.

## Timing
- Request sampled at edge E. ack_o and count_o are registered and valid for exactly the cycle after E. Latency is 1; throughput is 1 request per cycle.
- The snapshot includes any trig_i asserted in the request cycle.
- ovf_o updates at the edge where the wrap occurs and is visible the next cycle.
- Reset values (async on reset_n=0): all cnt, shadow = 0; ptr = 0; ack_o = 0; count_o = 0; ovf_o = 0. Reset during a pending response drops it: ack_o=0 immediately.
- After reset_n deasserts, the first edge can accept triggers and requests.

## Configuration
- ATOMIC_CTR_CLEAR_ON_READ_EN
  - Defined: a valid atomic read loads cnt[sel] <= 0 at the snapshot edge. The shadow still captures cnt+trig, so no event is lost. A trig in the next cycle counts from 0.
  - Undefined: reads never modify counters.

## Test plan
- Reset, then trig_i[0] held 5 cycles; atomic read ch0 in cycle 6 (no trig) -> ack_o=1 next cycle, count_o=5. Follow-up non-atomic read -> count_o=0.
- Preload ch2 = 0x0000_0001_FFFF_FFFF via triggers/force; trig in the request cycle of an atomic read -> count_o=0x0000_0000. Keep triggering 10 cycles, then non-atomic read -> count_o=0x0000_0002. Counter live value differs from the snapshot.
- ch1 at 0xFFFF_FFFF_FFFF_FFFF plus trig -> counter 0, ovf_o[1]=1 next cycle. Atomic read ch1 -> ovf_o[1]=0. Repeat with a wrap in the read cycle -> ovf_o[1] stays 1.
- Back-to-back: atomic, non-atomic, non-atomic on CNT_W=64 -> words 0, 1, 0 (ptr wraps). ack_o high 3 consecutive cycles.
- NUM_CH=3, atomic read with ch_sel_i=3 -> ack_o=1, count_o=0. A subsequent non-atomic read returns the prior shadow word 1.
- With ATOMIC_CTR_CLEAR_ON_READ_EN: ch0=7, atomic read with trig -> count_o=8, cnt[0]=0. One more trig, then atomic read -> count_o=1. Assert reset_n=0 mid-response -> ack_o=0, count_o=0 asynchronously.

Source files
------------

// File: rtl/atomic_counter_bank_if.sv
// Register-bus read port of atomic_counter_bank.
//   master : drives req_i, atomic_i, ch_sel_i; receives ack_o, count_o
//   slave  : the counter bank side
// SEL_W and BUS_W must match the bank instance that uses it.
//   req_i     read request, one per cycle, no backpressure
//   atomic_i  1 = snapshot selected channel and return word 0,
//             0 = return next word of the existing snapshot
//   ch_sel_i  channel for an atomic read
//   ack_o     registered response valid, one cycle after the request
//   count_o   response word, 0 whenever ack_o is low
interface atomic_counter_bank_if #(
  parameter int SEL_W = 2,
  parameter int BUS_W = 32
);
  logic             req_i;
  logic             atomic_i;
  logic [SEL_W-1:0] ch_sel_i;
  logic             ack_o;
  logic [BUS_W-1:0] count_o;

  modport master (output req_i, atomic_i, ch_sel_i, input ack_o, count_o);
  modport slave  (input req_i, atomic_i, ch_sel_i, output ack_o, count_o);
endinterface

// File: rtl/atomic_counter_bank.sv
// Multi-channel event counter bank with tear-free readout of wide counters
// over a narrow bus. An atomic read copies the selected counter (including
// a trigger in the same cycle) into one shared shadow register and returns
// its low word; non-atomic reads walk the remaining shadow words while the
// live counters keep running.
//
// Ports:
//   clk       single clock, rising edge
//   reset_n   asynchronous active-low reset
//   trig_i    per-channel increment pulse (+1 per cycle high)
//   bus       atomic_counter_bank_if.slave read port (req/atomic/ch_sel in,
//             ack/count out, 1-cycle latency)
//   ovf_o     sticky per-channel wrap flag, cleared by an atomic read of
//             that channel unless it wraps again in the same cycle
//
// Build option ATOMIC_CTR_CLEAR_ON_READ_EN: when defined, a valid atomic read
// also zeroes the selected counter; the snapshot still holds cnt+trig so no
// event is lost. When undefined, reads never modify the counters.
module atomic_counter_bank #(
  parameter int  NUM_CH = 4,
  parameter int  CNT_W  = 64,
  parameter int  BUS_W  = 32,
  localparam int NWORDS = CNT_W / BUS_W,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PTR_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_CH-1:0]    trig_i,
  atomic_counter_bank_if.slave bus,
  output logic [NUM_CH-1:0]    ovf_o
);

  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt  [NUM_CH];
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] sel_hit;
  logic [CNT_W-1:0]  shadow;
  logic [CNT_W-1:0]  snap;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_inc;
  logic [BUS_W-1:0]  word_sel;
  logic              sel_ok;
  logic              rd_snap;
  logic              rd_next;
  logic              ack_q;
  logic [BUS_W-1:0]  count_q;

  always_comb begin
    // Extra top bit keeps the range check correct when NUM_CH == 2**SEL_W.
    sel_ok  = ({1'b0, bus.ch_sel_i} < (SEL_W+1)'(NUM_CH));
    rd_snap = bus.req_i & bus.atomic_i & sel_ok;
    rd_next = bus.req_i & ~bus.atomic_i;
    snap    = '0;
    sel_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_nxt[c] = cnt[c] + CNT_W'(trig_i[c]);
      wrap[c]    = trig_i[c] & (&cnt[c]);
      if (rd_snap && (bus.ch_sel_i == SEL_W'(c))) begin
        sel_hit[c] = 1'b1;
        snap       = cnt_nxt[c];
      end
    end
    word_sel = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (ptr == PTR_W'(k)) word_sel = shadow[k*BUS_W +: BUS_W];
    end
    ptr_inc = (ptr == PTR_W'(NWORDS - 1)) ? '0 : ptr + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
      ovf_o <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
`ifdef ATOMIC_CTR_CLEAR_ON_READ_EN
        cnt[c] <= sel_hit[c] ? '0 : cnt_nxt[c];
`else
        cnt[c] <= cnt_nxt[c];
`endif
        // A wrap in the read cycle outranks the read's clear.
        if (wrap[c])         ovf_o[c] <= 1'b1;
        else if (sel_hit[c]) ovf_o[c] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow  <= '0;
      ptr     <= '0;
      ack_q   <= 1'b0;
      count_q <= '0;
    end else begin
      ack_q   <= bus.req_i;
      count_q <= '0;
      if (rd_snap) begin
        shadow  <= snap;
        ptr     <= PTR_W'(1 % NWORDS);
        count_q <= snap[BUS_W-1:0];
      end else if (rd_next) begin
        ptr     <= ptr_inc;
        count_q <= word_sel;
      end
      // Out-of-range atomic read: ack with zero data, shadow/ptr untouched.
    end
  end

  assign bus.ack_o   = ack_q;
  assign bus.count_o = count_q;

endmodule

// File: tb/tb_atomic_counter_bank.sv
// Bench for atomic_counter_bank. Two instances share one clock:
//   dut_a : NUM_CH=4, CNT_W=64, BUS_W=32 (default geometry)
//   dut_b : NUM_CH=3, CNT_W=8,  BUS_W=4  (small counters so wraps and
//           multi-word snapshots are reachable by triggering)
// A behavioural model pushes expected read words into a per-instance queue
// as each request is driven; the test tasks pop and compare on the response.
module tb_atomic_counter_bank;

  logic       clk = 1'b0;
  logic       rst_a_n;
  logic       rst_b_n;
  logic [3:0] trig_a;
  logic [2:0] trig_b;
  logic [3:0] ovf_a;
  logic [2:0] ovf_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] mcnt [2][4];
  logic [63:0] msh  [2];
  int          mptr [2];
  logic [3:0]  movf [2];
  logic [31:0] q_a [$];
  logic [31:0] q_b [$];

  atomic_counter_bank_if #(.SEL_W(2), .BUS_W(32)) bus_a ();
  atomic_counter_bank_if #(.SEL_W(2), .BUS_W(4))  bus_b ();

  atomic_counter_bank #(.NUM_CH(4), .CNT_W(64), .BUS_W(32)) dut_a (
    .clk(clk), .reset_n(rst_a_n), .trig_i(trig_a), .bus(bus_a), .ovf_o(ovf_a)
  );

  atomic_counter_bank #(.NUM_CH(3), .CNT_W(8), .BUS_W(4)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .trig_i(trig_b), .bus(bus_b), .ovf_o(ovf_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset(input int d);
    for (int c = 0; c < 4; c++) mcnt[d][c] = '0;
    msh[d]  = '0;
    mptr[d] = 0;
    movf[d] = '0;
    if (d == 0) q_a.delete(); else q_b.delete();
  endtask

  // One clock cycle on instance d: drive inputs, advance the model, wait
  // for the edge, then return 1 time unit after it with inputs idle.
  task automatic cyc(input int d, input logic [3:0] t, input logic r,
                     input logic a, input logic [1:0] s);
    int          cw, bw, nch;
    logic [63:0] mask, wmask, inc;
    logic [31:0] word;
    logic        hit;
    cw    = (d == 0) ? 64 : 8;
    bw    = (d == 0) ? 32 : 4;
    nch   = (d == 0) ? 4 : 3;
    mask  = (cw == 64) ? '1 : ((64'd1 << cw) - 64'd1);
    wmask = (64'd1 << bw) - 64'd1;
    if (d == 0) begin
      trig_a = t; bus_a.req_i = r; bus_a.atomic_i = a; bus_a.ch_sel_i = s;
    end else begin
      trig_b = t[2:0]; bus_b.req_i = r; bus_b.atomic_i = a; bus_b.ch_sel_i = s;
    end
    hit  = r && a && (int'(s) < nch);
    word = '0;
    if (r && a && hit) begin
      inc     = (mcnt[d][s] + 64'(t[s])) & mask;
      msh[d]  = inc;
      mptr[d] = 1;
      word    = 32'(inc & wmask);
    end else if (r && !a) begin
      word    = 32'((msh[d] >> (mptr[d] * bw)) & wmask);
      mptr[d] = (mptr[d] + 1) % (cw / bw);
    end
    for (int c = 0; c < nch; c++) begin
      if (t[c] && mcnt[d][c] == mask)    movf[d][c] = 1'b1;
      else if (hit && int'(s) == c)      movf[d][c] = 1'b0;
      mcnt[d][c] = (mcnt[d][c] + 64'(t[c])) & mask;
`ifdef ATOMIC_CTR_CLEAR_ON_READ_EN
      if (hit && int'(s) == c) mcnt[d][c] = '0;
`endif
    end
    if (r) begin
      if (d == 0) q_a.push_back(word); else q_b.push_back(word);
    end
    @(posedge clk);
    #1;
    if (d == 0) begin
      trig_a = '0; bus_a.req_i = 1'b0; bus_a.atomic_i = 1'b0; bus_a.ch_sel_i = '0;
    end else begin
      trig_b = '0; bus_b.req_i = 1'b0; bus_b.atomic_i = 1'b0; bus_b.ch_sel_i = '0;
    end
  endtask

  task automatic test_reset;
    trig_a = '0; bus_a.req_i = 1'b0; bus_a.atomic_i = 1'b0; bus_a.ch_sel_i = '0;
    trig_b = '0; bus_b.req_i = 1'b0; bus_b.atomic_i = 1'b0; bus_b.ch_sel_i = '0;
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    #2;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    model_reset(0); model_reset(1);
    #1;
    n_cmp++;
    if (bus_a.ack_o !== 1'b0 || bus_a.count_o !== 32'd0 || ovf_a !== 4'd0) begin
      n_err++;
      $display("FAIL reset_a: ack=%b count=%h ovf=%b, expected 0/0/0", bus_a.ack_o, bus_a.count_o, ovf_a);
    end
    n_cmp++;
    if (bus_b.ack_o !== 1'b0 || bus_b.count_o !== 4'd0 || ovf_b !== 3'd0) begin
      n_err++;
      $display("FAIL reset_b: ack=%b count=%h ovf=%b, expected 0/0/0", bus_b.ack_o, bus_b.count_o, ovf_b);
    end
    @(posedge clk);
    #1;
    rst_a_n = 1'b1; rst_b_n = 1'b1;
  endtask

  task automatic test_pre_snapshot;
    logic [31:0] exp;
    cyc(0, 4'd0, 1'b1, 1'b0, 2'd0);
    exp = q_a.pop_front();
    n_cmp++;
    if (bus_a.ack_o !== 1'b1 || bus_a.count_o !== exp || bus_a.count_o !== 32'd0) begin
      n_err++;
      $display("FAIL pre_snap_a: ack=%b count=%h, expected ack=1 count=%h", bus_a.ack_o, bus_a.count_o, exp);
    end
    cyc(1, 4'd0, 1'b1, 1'b0, 2'd0);
    exp = q_b.pop_front();
    n_cmp++;
    if (bus_b.ack_o !== 1'b1 || 32'(bus_b.count_o) !== exp || bus_b.count_o !== 4'd0) begin
      n_err++;
      $display("FAIL pre_snap_b: ack=%b count=%h, expected ack=1 count=%h", bus_b.ack_o, bus_b.count_o, exp);
    end
  endtask

  task automatic test_basic;
    logic [31:0] exp;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 4'b0001, 1'b0, 1'b0, 2'd0);
      n_cmp++;
      if (bus_a.ack_o !== 1'b0 || bus_a.count_o !== 32'd0) begin
        n_err++;
        $display("FAIL basic_idle%0d: ack=%b count=%h, expected 0/0", i, bus_a.ack_o, bus_a.count_o);
      end
    end
    cyc(0, 4'd0, 1'b1, 1'b1, 2'd0);
    exp = q_a.pop_front();
    n_cmp++;
    if (bus_a.ack_o !== 1'b1 || bus_a.count_o !== exp || bus_a.count_o !== 32'd5) begin
      n_err++;
      $display("FAIL basic_atomic: ack=%b count=%h, expected ack=1 count=%h (5)", bus_a.ack_o, bus_a.count_o, exp);
    end
    cyc(0, 4'd0, 1'b1, 1'b0, 2'd0);
    exp = q_a.pop_front();
    n_cmp++;
    if (bus_a.ack_o !== 1'b1 || bus_a.count_o !== exp || bus_a.count_o !== 32'd0) begin
      n_err++;
      $display("FAIL basic_word1: ack=%b count=%h, expected ack=1 count=%h (0)", bus_a.ack_o, bus_a.count_o, exp);
    end
  endtask

  task automatic test_snapshot;
    logic [31:0] exp;
    for (int i = 0; i < 31; i++) cyc(1, 4'b0100, 1'b0, 1'b0, 2'd0);
    cyc(1, 4'b0100, 1'b1, 1'b1, 2'd2);
    exp = q_b.pop_front();
    n_cmp++;
    if (bus_b.ack_o !== 1'b1 || 32'(bus_b.count_o) !== exp || bus_b.count_o !== 4'h0) begin
      n_err++;
      $display("FAIL snap_word0: ack=%b count=%h, expected ack=1 count=%h (0)", bus_b.ack_o, bus_b.count_o, exp);
    end
    for (int i = 0; i < 10; i++) cyc(1, 4'b0100, 1'b0, 1'b0, 2'd0);
    cyc(1, 4'd0, 1'b1, 1'b0, 2'd0);
    exp = q_b.pop_front();
    n_cmp++;
    if (bus_b.ack_o !== 1'b1 || 32'(bus_b.count_o) !== exp || bus_b.count_o !== 4'h2) begin
      n_err++;
      $display("FAIL snap_word1: ack=%b count=%h, expected ack=1 count=%h (2)", bus_b.ack_o, bus_b.count_o, exp);
    end
    cyc(1, 4'd0, 1'b1, 1'b1, 2'd2);
    exp = q_b.pop_front();
    n_cmp++;
    if (bus_b.ack_o !== 1'b1 || 32'(bus_b.count_o) !== exp || bus_b.count_o !== 4'hA) begin
      n_err++;
      $display("FAIL snap_live: ack=%b count=%h, expected ack=1 count=%h (a)", bus_b.ack_o, bus_b.count_o, exp);
    end
    cyc(1, 4'd0, 1'b1, 1'b0, 2'd0);
    exp = q_b.pop_front();
    n_cmp++;
    if (bus_b.ack_o !== 1'b1 || 32'(bus_b.count_o) !== exp) begin
      n_err++;
      $display("FAIL snap_live_word1: ack=%b count=%h, expected ack=1 count=%h", bus_b.ack_o, bus_b.count_o, exp);
    end
  endtask

  task automatic test_ovf;
    logic [31:0] exp;
    for (int i = 0; i < 256; i++) cyc(1, 4'b0010, 1'b0, 1'b0, 2'd0);
    n_cmp++;
    if (ovf_b !== movf[1][2:0] || ovf_b !== 3'b010) begin
      n_err++;
      $display("FAIL ovf_set: ovf=%b, expected %b", ovf_b, movf[1][2:0]);
    end
    cyc(1, 4'd0, 1'b1, 1'b1, 2'd1);
    exp = q_b.pop_front();
    n_cmp++;
    if (bus_b.ack_o !== 1'b1 || 32'(bus_b.count_o) !== exp || bus_b.count_o !== 4'h0) begin
      n_err++;
      $display("FAIL ovf_read: ack=%b count=%h, expected ack=1 count=%h", bus_b.ack_o, bus_b.count_o, exp);
    end
    n_cmp++;
    if (ovf_b !== movf[1][2:0] || ovf_b[1] !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: ovf=%b, expected %b", ovf_b, movf[1][2:0]);
    end
    for (int i = 0; i < 255; i++) cyc(1, 4'b0010, 1'b0, 1'b0, 2'd0);
    cyc(1, 4'b0010, 1'b1, 1'b1, 2'd1);
    exp = q_b.pop_front();
    n_cmp++;
    if (bus_b.ack_o !== 1'b1 || 32'(bus_b.count_o) !== exp) begin
      n_err++;
      $display("FAIL ovf_wrap_read: ack=%b count=%h, expected ack=1 count=%h", bus_b.ack_o, bus_b.count_o, exp);
    end
    n_cmp++;
    if (ovf_b !== movf[1][2:0] || ovf_b[1] !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_wrap_wins: ovf=%b, expected %b", ovf_b, movf[1][2:0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp;
    logic [31:0] fixed [3];
    fixed[0] = 32'd4; fixed[1] = 32'd0; fixed[2] = 32'd4;
    for (int i = 0; i < 3; i++) cyc(0, 4'b1000, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) cyc(0, 4'b1000, 1'b1, 1'b1, 2'd3);
      else        cyc(0, 4'b1111, 1'b1, 1'b0, 2'd0);
      exp = q_a.pop_front();
      n_cmp++;
      if (bus_a.ack_o !== 1'b1 || bus_a.count_o !== exp || bus_a.count_o !== fixed[i]) begin
        n_err++;
        $display("FAIL b2b_%0d: ack=%b count=%h, expected ack=1 count=%h", i, bus_a.ack_o, bus_a.count_o, fixed[i]);
      end
    end
    cyc(0, 4'd0, 1'b0, 1'b0, 2'd0);
    n_cmp++;
    if (bus_a.ack_o !== 1'b0 || bus_a.count_o !== 32'd0) begin
      n_err++;
      $display("FAIL b2b_idle: ack=%b count=%h, expected 0/0", bus_a.ack_o, bus_a.count_o);
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] exp;
    for (int i = 0; i < 60; i++) cyc(1, 4'b0001, 1'b0, 1'b0, 2'd0);
    cyc(1, 4'd0, 1'b1, 1'b1, 2'd0);
    exp = q_b.pop_front();
    n_cmp++;
    if (bus_b.ack_o !== 1'b1 || 32'(bus_b.count_o) !== exp || bus_b.count_o !== 4'hC) begin
      n_err++;
      $display("FAIL oor_setup: ack=%b count=%h, expected ack=1 count=%h (c)", bus_b.ack_o, bus_b.count_o, exp);
    end
    cyc(1, 4'd0, 1'b1, 1'b1, 2'd3);
    exp = q_b.pop_front();
    n_cmp++;
    if (bus_b.ack_o !== 1'b1 || 32'(bus_b.count_o) !== exp || bus_b.count_o !== 4'h0) begin
      n_err++;
      $display("FAIL oor_read: ack=%b count=%h, expected ack=1 count=0", bus_b.ack_o, bus_b.count_o);
    end
    n_cmp++;
    if (ovf_b !== movf[1][2:0]) begin
      n_err++;
      $display("FAIL oor_ovf: ovf=%b, expected %b", ovf_b, movf[1][2:0]);
    end
    cyc(1, 4'd0, 1'b1, 1'b0, 2'd0);
    exp = q_b.pop_front();
    n_cmp++;
    if (bus_b.ack_o !== 1'b1 || 32'(bus_b.count_o) !== exp || bus_b.count_o !== 4'h3) begin
      n_err++;
      $display("FAIL oor_follow: ack=%b count=%h, expected ack=1 count=%h (3)", bus_b.ack_o, bus_b.count_o, exp);
    end
  endtask

  task automatic test_random;
    logic [31:0] exp;
    logic        r, a;
    logic [1:0]  s;
    logic [3:0]  t;
    for (int i = 0; i < 40; i++) begin
      r = ($urandom_range(0, 2) != 0);
      a = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      t = 4'($urandom_range(0, 15));
      cyc(0, t, r, a, s);
      if (r) begin
        exp = q_a.pop_front();
        n_cmp++;
        if (bus_a.ack_o !== 1'b1 || bus_a.count_o !== exp) begin
          n_err++;
          $display("FAIL rand_a_%0d: ack=%b count=%h, expected ack=1 count=%h", i, bus_a.ack_o, bus_a.count_o, exp);
        end
      end else begin
        n_cmp++;
        if (bus_a.ack_o !== 1'b0 || bus_a.count_o !== 32'd0) begin
          n_err++;
          $display("FAIL rand_a_idle_%0d: ack=%b count=%h, expected 0/0", i, bus_a.ack_o, bus_a.count_o);
        end
      end
      n_cmp++;
      if (ovf_a !== movf[0]) begin
        n_err++;
        $display("FAIL rand_a_ovf_%0d: ovf=%b, expected %b", i, ovf_a, movf[0]);
      end
    end
    for (int i = 0; i < 40; i++) begin
      r = ($urandom_range(0, 2) != 0);
      a = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      t = 4'($urandom_range(0, 7));
      cyc(1, t, r, a, s);
      if (r) begin
        exp = q_b.pop_front();
        n_cmp++;
        if (bus_b.ack_o !== 1'b1 || 32'(bus_b.count_o) !== exp) begin
          n_err++;
          $display("FAIL rand_b_%0d: ack=%b count=%h, expected ack=1 count=%h", i, bus_b.ack_o, bus_b.count_o, exp);
        end
      end
      n_cmp++;
      if (ovf_b !== movf[1][2:0]) begin
        n_err++;
        $display("FAIL rand_b_ovf_%0d: ovf=%b, expected %b", i, ovf_b, movf[1][2:0]);
      end
    end
  endtask

  task automatic test_reset_mid_response;
    logic [31:0] exp;
    cyc(0, 4'd0, 1'b1, 1'b1, 2'd3);
    exp = q_a.pop_front();
    n_cmp++;
    if (bus_a.ack_o !== 1'b1 || bus_a.count_o !== exp) begin
      n_err++;
      $display("FAIL rst_mid_pre: ack=%b count=%h, expected ack=1 count=%h", bus_a.ack_o, bus_a.count_o, exp);
    end
    #1;
    rst_a_n = 1'b0;
    model_reset(0);
    #1;
    n_cmp++;
    if (bus_a.ack_o !== 1'b0 || bus_a.count_o !== 32'd0 || ovf_a !== 4'd0) begin
      n_err++;
      $display("FAIL rst_mid_drop: ack=%b count=%h ovf=%b, expected 0/0/0", bus_a.ack_o, bus_a.count_o, ovf_a);
    end
    rst_a_n = 1'b1;
  endtask

  task automatic test_clear_on_read;
    logic [31:0] exp;
    logic [31:0] want2;
`ifdef ATOMIC_CTR_CLEAR_ON_READ_EN
    want2 = 32'd1;
`else
    want2 = 32'd9;
`endif
    for (int i = 0; i < 7; i++) cyc(0, 4'b0001, 1'b0, 1'b0, 2'd0);
    cyc(0, 4'b0001, 1'b1, 1'b1, 2'd0);
    exp = q_a.pop_front();
    n_cmp++;
    if (bus_a.ack_o !== 1'b1 || bus_a.count_o !== exp || bus_a.count_o !== 32'd8) begin
      n_err++;
      $display("FAIL clr_first: ack=%b count=%h, expected ack=1 count=8", bus_a.ack_o, bus_a.count_o);
    end
    cyc(0, 4'b0001, 1'b0, 1'b0, 2'd0);
    cyc(0, 4'd0, 1'b1, 1'b1, 2'd0);
    exp = q_a.pop_front();
    n_cmp++;
    if (bus_a.ack_o !== 1'b1 || bus_a.count_o !== exp || bus_a.count_o !== want2) begin
      n_err++;
      $display("FAIL clr_second: ack=%b count=%h, expected ack=1 count=%h", bus_a.ack_o, bus_a.count_o, want2);
    end
  endtask

  initial begin
    test_reset();
    test_pre_snapshot();
    test_basic();
    test_snapshot();
    test_ovf();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_reset_mid_response();
    test_clear_on_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
